// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: integer register file with busy scoreboard.
//
// NRD combinational read ports, one writeback port, and a per-register busy bit
// for in-flight producers. After reset a clear engine zeroes one entry per cycle,
// so the array has no global reset and can map to distributed RAM. `ready` stays
// low until the sweep has covered every entry.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   we/wa/wd   writeback enable, address, data
//   ra         packed read addresses, port i at [i*AW +: AW]
//   rd         packed read data, port i at [i*XLEN +: XLEN]
//   iss_valid  issue strobe; marks iss_addr busy
//   iss_addr   destination register of the issued instruction
//   rd_busy    per read port: source has an in-flight producer
//   ready      clear sweep complete
//
// Optional feature: define RISCV_REGFILE_BYPASS_EN to forward a same-cycle
// writeback to matching read ports and mask their busy flag.
module riscv_regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NRD-1:0]      rd_busy,
  output logic                ready
);

  localparam logic [AW:0]   NRegW   = (AW+1)'(NREG);
  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [XLEN-1:0]     rf_q [NREG];

  logic                rf_we;
  logic [AW-1:0]       rf_wa;
  logic [XLEN-1:0]     rf_wd;
  logic                wr_ok;
  logic                iss_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NRegW);
  endfunction

  // Architectural write / issue qualifiers (entry 0 and out-of-range dropped).
  assign wr_ok  = (state_q == StReady) && we && (wa != '0) && in_range(wa);
  assign iss_ok = (state_q == StReady) && iss_valid && (iss_addr != '0) && in_range(iss_addr);
  assign ready  = (state_q == StReady);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    rf_we     = 1'b0;
    rf_wa     = clr_idx_q;
    rf_wd     = '0;
    unique case (state_q)
      StClear: begin
        rf_we     = ~rst;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LastIdx) state_d = StReady;
      end
      StReady: begin
        if (wr_ok) begin
          rf_we      = 1'b1;
          rf_wa      = wa;
          rf_wd      = wd;
          busy_d[wa] = 1'b0;
        end
        // Applied after the clear: a new producer supersedes the retiring one.
        if (iss_ok) busy_d[iss_addr] = 1'b1;
      end
      default: state_d = StClear;
    endcase
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  // Storage deliberately has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[rf_wa] <= rf_wd;
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = ra[i*AW +: AW];
      if ((state_q == StReady) && (a != '0) && in_range(a)) begin
        rd[i*XLEN +: XLEN] = rf_q[a];
        rd_busy[i]         = busy_q[a];
`ifdef RISCV_REGFILE_BYPASS_EN
        if (wr_ok && (wa == a)) begin
          rd[i*XLEN +: XLEN] = wd;
          rd_busy[i]         = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
module tb_riscv_regfile_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [NRD-1:0]      rd_busy;
  logic                ready;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_regfile_sb #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .rd_busy   (rd_busy),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic iv, input logic [4:0] ia,
                       input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; iss_valid = iv; iss_addr = ia;
    ra = {r1, r0};
  endtask

  // Clock edge, then settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the NREG-edge clear sweep while hammering writes/issues that must be ignored.
  task automatic sweep(input string tag);
    for (int k = 1; k <= int'(NREG); k++) begin
      if (k < int'(NREG)) drive(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4, 5'd4, 5'd5);
      tick();
      if (k == int'(NREG)) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd5);
      #1;
      chk($sformatf("%s_ready_e%0d", tag, k), 64'(ready), 64'(k == int'(NREG)));
      if (k < int'(NREG)) begin
        chk($sformatf("%s_rd_e%0d", tag, k), 64'(rd), 64'h0);
        chk($sformatf("%s_busy_e%0d", tag, k), 64'(rd_busy), 64'h0);
      end
    end
    // Writes/issues during the sweep must not have landed.
    chk({tag, "_x4_after"}, 64'(rd[31:0]), 64'h0);
    chk({tag, "_busy_after"}, 64'(rd_busy), 64'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd0, 32'h0,        32'h0,        2'b00};
    vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd0,  5'd0, 32'h0,        32'h0,        2'b00};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5, 32'h0,        32'hDEADBEEF, 2'b01};
    vecs[4]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7, 32'h55,       32'h55,       2'b00};
    vecs[6]  = '{1'b1, 5'd9,  32'h00000001, 1'b1, 5'd9,  5'd5,  5'd7, 32'hDEADBEEF, 32'h55,       2'b00};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9, 32'h1,        32'h1,        2'b11};
    vecs[8]  = '{1'b1, 5'd9,  32'h00000002, 1'b1, 5'd10, 5'd10, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd10, 32'h2,       32'h0,        2'b10};
    vecs[10] = '{1'b1, 5'd10, 32'h0000AAAA, 1'b1, 5'd0,  5'd9,  5'd0, 32'h2,        32'h0,        2'b00};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd0, 32'hAAAA,     32'h0,        2'b00};

    // Power-on reset, two cycles.
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_busy", 64'(rd_busy), 64'h0);
    rst = 1'b0;
    sweep("por");

    // Main table: outputs checked before each edge, then clocked.
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iv, vecs[i].ia, vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("v%0d_rd0", i), 64'(rd[31:0]), 64'(vecs[i].e_rd0));
      chk($sformatf("v%0d_rd1", i), 64'(rd[63:32]), 64'(vecs[i].e_rd1));
      chk($sformatf("v%0d_busy", i), 64'(rd_busy), 64'(vecs[i].e_busy));
      tick();
    end

    // Bypass: x3 busy and holding 0, written this cycle while port 1 reads it.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3);
    tick();
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd3);
    #1;
`ifdef RISCV_REGFILE_BYPASS_EN
    chk("byp_rd1", 64'(rd[63:32]), 64'hA5A5A5A5);
    chk("byp_busy", 64'(rd_busy), 64'h0);
`else
    chk("byp_rd1", 64'(rd[63:32]), 64'h0);
    chk("byp_busy", 64'(rd_busy), 64'h2);
`endif
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd3);
    #1;
    chk("byp_after_rd1", 64'(rd[63:32]), 64'hA5A5A5A5);
    chk("byp_after_busy", 64'(rd_busy), 64'h0);

    // Mid-operation reset.
    drive(1'b1, 5'd5, 32'h00000077, 1'b1, 5'd6, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    #1;
    chk("mid_pre_rd0", 64'(rd[31:0]), 64'h77);
    chk("mid_pre_busy", 64'(rd_busy), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'h0);
    chk("mid_rst_busy", 64'(rd_busy), 64'h0);
    chk("mid_rst_rd", 64'(rd), 64'h0);
    sweep("mid");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    #1;
    chk("mid_x5", 64'(rd[31:0]), 64'h0);
    chk("mid_x6", 64'(rd[63:32]), 64'h0);
    chk("mid_busy6", 64'(rd_busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
